// File: rtl/sub4bit_serial.sv
// Bit-serial subtractor: diff = a - b computed LSB first through one
// full-subtractor cell and a borrow flop, with valid/ready on both sides.
module sub4bit_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds data stable while valid is high and ready low.

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             bit_a, bit_b;
  logic             d, br_nxt;
  logic             last;

  assign bit_a  = a_r[cnt];
  assign bit_b  = b_r[cnt];
  assign d      = bit_a ^ bit_b ^ br;
  assign br_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // diff is filled from the MSB side, so after WIDTH shifts bit 0 sits at LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      diff <= '0;
      bo   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            cnt <= '0;
            br  <= 1'b0;
          end
        end
        RUN: begin
          diff <= {d, diff[WIDTH-1:1]};
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          if (last) bo <= br_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub4bit_serial.sv
// Self-checking bench for sub4bit_serial: vector table, corner-case
// sequences and an exhaustive back-to-back sweep through a scoreboard queue.
module tb_sub4bit_serial;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bo;
  logic         busy;

  sub4bit_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bo(bo), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offers operands from a negedge, waits for acceptance, returns at the
  // negedge after the accepting edge.
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb);
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    a        = aa;
    b        = bb;
    acc_cyc  = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic recv(input string name);
    int k;
    logic [W:0] e;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_out_valid"}, out_valid, 1);
    if (out_valid) begin
      chk({name, "_latency"}, cyc - acc_cyc, W);
      if (exp_q.size() == 0) begin
        chk({name, "_queue_empty"}, 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk({name, "_diff"}, diff, e[W-1:0]);
        chk({name, "_bo"}, bo, e[W]);
      end
    end
  endtask

  initial begin
    vecs[0] = '{a: 4'd9,  b: 4'd5,  d: 4'd4,  bo: 1'b0};
    vecs[1] = '{a: 4'd5,  b: 4'd9,  d: 4'd12, bo: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd1,  d: 4'd15, bo: 1'b1};
    vecs[3] = '{a: 4'd15, b: 4'd15, d: 4'd0,  bo: 1'b0};
    vecs[4] = '{a: 4'd0,  b: 4'd0,  d: 4'd0,  bo: 1'b0};
    vecs[5] = '{a: 4'd12, b: 4'd3,  d: 4'd9,  bo: 1'b0};
    vecs[6] = '{a: 4'd7,  b: 4'd2,  d: 4'd5,  bo: 1'b0};
    vecs[7] = '{a: 4'd3,  b: 4'd1,  d: 4'd2,  bo: 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bo", bo, 0);
    rst = 1'b0;

    // Basic vectors
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].a, vecs[i].b);
      exp_q.push_back({vecs[i].bo, vecs[i].d});
      recv($sformatf("vec%0d", i));
    end
    @(negedge clk);
    chk("idle_after_vec_in_ready", in_ready, 1);

    // Backpressure: result held, extra in_valid ignored
    out_ready = 1'b0;
    send(vecs[5].a, vecs[5].b);
    exp_q.push_back({vecs[5].bo, vecs[5].d});
    recv("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 4'd1; b = 4'd1;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_diff", diff, vecs[5].d);
      chk("bp_bo", bo, vecs[5].bo);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);
    @(negedge clk);
    chk("bp_no_ghost_busy", busy, 0);

    // Operands change during RUN
    send(vecs[6].a, vecs[6].b);
    exp_q.push_back({vecs[6].bo, vecs[6].d});
    a = 4'd0; b = 4'd15;
    recv("opchg");

    // Reset in second RUN cycle discards the operation
    send(4'd15, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bo", bo, 0);
    send(vecs[7].a, vecs[7].b);
    exp_q.push_back({vecs[7].bo, vecs[7].d});
    recv("postrst");

    // Exhaustive back-to-back sweep
    begin
      int idx, got, prev_acc;
      logic [W-1:0] ea, eb, ed;
      logic [W:0]   e;
      idx = 0; got = 0; prev_acc = -1;
      out_ready = 1'b1;
      for (int t = 0; t < 256 * 6 + 60 && got < 256; t++) begin
        @(negedge clk);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("exh_queue_empty", 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk("exh_diff", diff, e[W-1:0]);
            chk("exh_bo", bo, e[W]);
          end
          got++;
        end
        if (in_ready && idx < 256) begin
          ea = idx[7:4];
          eb = idx[3:0];
          ed = ea - eb;
          a = ea; b = eb; in_valid = 1'b1;
          exp_q.push_back({(ea < eb), ed});
          if (prev_acc >= 0) chk("exh_ii", cyc + 1 - prev_acc, 6);
          prev_acc = cyc + 1;
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      in_valid = 1'b0;
      chk("exh_result_count", got, 256);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
